sap_clock_ctrl: RTL and testbench
=================================

# sap_clock_ctrl

Parametrised clock/control unit for the SAP CPU family: replaces the fixed manual/auto clock gating of the SAP-1 top with a single-clock enable generator. Produces a one-cycle `sap_clk_en` pulse that all CPU registers qualify on. It debounces the front-panel switches, and supports:
- auto mode with a selectable divide ratio;
- manual single-step and burst-step;
- a sticky CPU halt.

Sits between the board inputs and the CPU core in the SAP top level.

## Interface
- DEBOUNCE_CYCLES, 25000, consecutive stable base-clock cycles required to accept a switch/button change (0.5 ms at 50 MHz)
- AUTO_DIV_BASE, 16, enable period in cycles at speed 0
- SPEED_W, 3, width of speed select; period = AUTO_DIV_BASE << sap_speed_sel
- BURST_W, 4, width of burst length
- CNT_W, 16, width of enable-pulse counter

Ports:
- sap_base_clock  in  1  sole clock, rising edge
- sap_CleanStart_pb  in  1  reset, asynchronous, active-low (0 = clear)
- sap_ManualAuto_sw  in  1  raw switch, 1 = auto, 0 = manual
- sap_SingleStep_pb  in  1  raw button, step on debounced rising edge
- sap_speed_sel  in  SPEED_W  auto/burst rate select
- sap_burst_len  in  BURST_W  enables per manual press; 0 treated as 1
- sap_hlt  in  1  CPU HLT, synchronous to sap_base_clock
- sap_clk_en  out  1  one-cycle CPU enable pulse
- sap_mode_auto  out  1  debounced mode
- sap_halted  out  1  high in HALT state
- sap_step_count  out  CNT_W  number of sap_clk_en pulses since reset

## Operation
- Each raw input passes through a 2-flop synchroniser, then a debouncer.
  - Debounced output takes the new level after DEBOUNCE_CYCLES consecutive equal samples.
  - Debounced output resets to 0.
- Divider counter `div` runs 0..P-1, with P = AUTO_DIV_BASE << spd_q.
  - `tick` is asserted when div == P-1.
  - spd_q is loaded from sap_speed_sel only at wrap and at reset (reset value = input sampled 0). A mid-period change never truncates the current period.
  - Counter width: $clog2(AUTO_DIV_BASE << (2**SPEED_W-1)).
  - div is cleared on every state entry except BURST→BURST.
- States:
  - MANUAL (reset state):
    - mode_auto=1 → AUTO.
    - Step rising edge → BURST, with rem = (sap_burst_len==0) ? 1 : sap_burst_len.
    - Step edge and mode_auto=1 in the same cycle: AUTO wins, the step is discarded.
  - AUTO:
    - sap_clk_en = tick.
    - mode_auto=0 → MANUAL; no pulse in the transition cycle.
  - BURST:
    - sap_clk_en = tick; rem decrements per pulse.
    - After the pulse with rem==1 → MANUAL.
    - Mode change and step edges are ignored until the burst completes.
  - HALT:
    - No pulses; sap_halted=1.
    - Exit only via reset.
- sap_hlt=1 in any state → HALT next cycle.
  - If tick coincides with sap_hlt, hlt wins: no pulse.
- sap_step_count increments on every sap_clk_en and wraps modulo 2^CNT_W.

## Timing
- Reset values: sap_clk_en=0, sap_mode_auto=0, sap_halted=0, sap_step_count=0, state=MANUAL, div=0, rem=0.
- Reset assertion mid-burst or mid-period aborts immediately, asynchronously.
- Input-to-debounced latency: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Step-edge-to-first-pulse latency: P cycles after BURST entry.
- sap_clk_en is registered and is never high for two consecutive cycles (P ≥ 2 is required; AUTO_DIV_BASE ≥ 2).
- All outputs are registered.

## Structure
- Package sap_clk_pkg: state enum (MANUAL, AUTO, BURST, HALT), default parameter constants, and a localparam function for the divider width.
- Sub-module sap_debounce (parameter DEBOUNCE_CYCLES; synchroniser plus stable counter), instantiated twice (mode, step).
- Divider, FSM, burst counter and step counter live in sap_clock_ctrl.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, AUTO_DIV_BASE=4, 20 ns clock.
1. Reset, auto=1, speed=0 → mode_auto rises 6 cycles after switch; pulses every 4 cycles; step_count=10 after 40 cycles in AUTO.
2. Manual, burst_len=3, speed=1, clean step press → exactly 3 pulses, 8 cycles apart; return to MANUAL; step_count=3.
3. burst_len=0 press → exactly 1 pulse. A 3-cycle step glitch → no pulse.
4. AUTO, speed changed 0→2 mid-period → current 4-cycle period completes, then periods of 16 cycles.
5. sap_hlt asserted on the same cycle as tick → no pulse, sap_halted=1; further step presses and mode changes are ignored until reset.
6. Reset asserted mid-burst (rem=2) → all outputs 0 immediately; after release, MANUAL with no residual pulses.

Source files
------------

// File: rtl/sap_clk_pkg.sv
// sap_clk_pkg: shared types and constants for the SAP clock/control unit.
//   state_t    - control FSM states (MANUAL is the reset state)
//   DEF_*      - default parameter values for sap_clock_ctrl / sap_debounce
//   div_width  - width of the auto/burst divider counter so the longest
//                period (base << max speed) still counts 0..P-1
package sap_clk_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    BURST  = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 25000;
  localparam int DEF_AUTO_DIV_BASE   = 16;
  localparam int DEF_SPEED_W         = 3;
  localparam int DEF_BURST_W         = 4;
  localparam int DEF_CNT_W           = 16;

  function automatic int div_width(input int base, input int speed_w);
    return $clog2(base << ((1 << speed_w) - 1));
  endfunction

endpackage

// File: rtl/sap_debounce.sv
// sap_debounce: 2-flop synchroniser followed by a stable-level counter.
//   i_clk    - base clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_raw    - raw, asynchronous switch/button level
//   o_db     - debounced level (registered, resets to 0)
// The debounced level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive samples that differ from the current output,
// so total latency from i_raw to o_db is 2 + DEBOUNCE_CYCLES cycles.
module sap_debounce
  import sap_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample equal to the current output restarts the run, so a
      // glitch shorter than DEBOUNCE_CYCLES never reaches o_db.
      if (r_sync2 != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/sap_clock_ctrl.sv
// sap_clock_ctrl: single-clock enable generator for the SAP CPU family.
//   sap_base_clock     - sole clock, rising edge
//   sap_CleanStart_pb  - asynchronous active-low reset
//   sap_ManualAuto_sw  - raw switch, 1 = auto, 0 = manual
//   sap_SingleStep_pb  - raw button, a burst starts on its debounced rising edge
//   sap_speed_sel      - period select, P = AUTO_DIV_BASE << speed
//   sap_burst_len      - enables per manual press (0 behaves as 1)
//   sap_hlt            - CPU halt request, synchronous
//   sap_clk_en         - one-cycle CPU enable pulse
//   sap_mode_auto      - debounced mode switch
//   sap_halted         - high while in HALT
//   sap_step_count     - sap_clk_en pulses since reset, wraps
//   o_dbg_state        - current FSM state
// sap_clk_en semantics: a registered single-cycle strobe with no back-pressure;
// every register in the CPU that samples on a cycle with sap_clk_en=1 counts
// as one CPU clock. It is never high on two consecutive cycles because P >= 2.
module sap_clock_ctrl
  import sap_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int AUTO_DIV_BASE   = DEF_AUTO_DIV_BASE,
  parameter int SPEED_W         = DEF_SPEED_W,
  parameter int BURST_W         = DEF_BURST_W,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic               sap_base_clock,
  input  logic               sap_CleanStart_pb,
  input  logic               sap_ManualAuto_sw,
  input  logic               sap_SingleStep_pb,
  input  logic [SPEED_W-1:0] sap_speed_sel,
  input  logic [BURST_W-1:0] sap_burst_len,
  input  logic               sap_hlt,
  output logic               sap_clk_en,
  output logic               sap_mode_auto,
  output logic               sap_halted,
  output logic [CNT_W-1:0]   sap_step_count,
  output state_t             o_dbg_state
);

  localparam int DIV_W = div_width(AUTO_DIV_BASE, SPEED_W);

  state_t             r_state;
  state_t             w_next_state;
  logic [DIV_W-1:0]   r_div;
  logic [SPEED_W-1:0] r_spd;
  logic [BURST_W-1:0] r_rem;
  logic               r_clk_en;
  logic               r_halted;
  logic [CNT_W-1:0]   r_count;
  logic               r_step_db_q;

  logic               w_mode_db;
  logic               w_step_db;
  logic               w_step_rise;
  logic [DIV_W:0]     w_period;
  logic               w_tick;
  logic               w_pulse;
  logic               w_load_rem;
  logic               w_dec_rem;

  sap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .i_clk   (sap_base_clock),
    .i_rst_n (sap_CleanStart_pb),
    .i_raw   (sap_ManualAuto_sw),
    .o_db    (w_mode_db)
  );

  sap_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .i_clk   (sap_base_clock),
    .i_rst_n (sap_CleanStart_pb),
    .i_raw   (sap_SingleStep_pb),
    .o_db    (w_step_db)
  );

  assign w_step_rise = w_step_db & ~r_step_db_q;

  // Period uses the latched speed so a mid-period change never shortens
  // the period already in progress.
  assign w_period = (DIV_W + 1)'(AUTO_DIV_BASE) << r_spd;
  assign w_tick   = ({1'b0, r_div} == (w_period - 1'b1));

  always_comb begin
    w_next_state = r_state;
    w_pulse      = 1'b0;
    w_load_rem   = 1'b0;
    w_dec_rem    = 1'b0;
    if (sap_hlt) begin
      // Halt beats a coincident tick: no pulse on the way into HALT.
      w_next_state = HALT;
    end else begin
      case (r_state)
        MANUAL: begin
          // Auto beats a simultaneous step edge; the step is dropped.
          if (w_mode_db) begin
            w_next_state = AUTO;
          end else if (w_step_rise) begin
            w_next_state = BURST;
            w_load_rem   = 1'b1;
          end
        end
        AUTO: begin
          if (!w_mode_db) begin
            w_next_state = MANUAL;
          end else begin
            w_pulse = w_tick;
          end
        end
        BURST: begin
          // Mode and step inputs are not looked at until the burst ends.
          if (w_tick) begin
            w_pulse   = 1'b1;
            w_dec_rem = 1'b1;
            if (r_rem <= BURST_W'(1)) begin
              w_next_state = MANUAL;
            end
          end
        end
        HALT: begin
          w_next_state = HALT;
        end
        default: begin
          w_next_state = MANUAL;
        end
      endcase
    end
  end

  always_ff @(posedge sap_base_clock or negedge sap_CleanStart_pb) begin
    if (!sap_CleanStart_pb) begin
      r_state     <= MANUAL;
      r_div       <= '0;
      r_spd       <= '0;
      r_rem       <= '0;
      r_clk_en    <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
      r_step_db_q <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_clk_en    <= w_pulse;
      r_halted    <= (w_next_state == HALT);
      r_count     <= r_count + CNT_W'(w_pulse);
      r_step_db_q <= w_step_db;

      // Restart the period on any state change so the first pulse after
      // entering AUTO or BURST comes a full P cycles later.
      if (w_next_state != r_state) begin
        r_div <= '0;
      end else if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_tick) begin
        r_spd <= sap_speed_sel;
      end

      if (w_load_rem) begin
        r_rem <= (sap_burst_len == '0) ? BURST_W'(1) : sap_burst_len;
      end else if (w_dec_rem) begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  assign sap_clk_en     = r_clk_en;
  assign sap_mode_auto  = w_mode_db;
  assign sap_halted     = r_halted;
  assign sap_step_count = r_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// tb_sap_clock_ctrl: directed bench for sap_clock_ctrl with
// DEBOUNCE_CYCLES=4, AUTO_DIV_BASE=4 and a 20 ns clock.
// Inputs change just after a falling edge at cycle c (c = rising edges so
// far); with 2 sync flops and 4 debounce samples the debounced level moves at
// edge c+6 and the FSM changes state at edge c+7. Expected pulses are
// (edge number, step count) pairs queued when stimulus is issued.
module tb_sap_clock_ctrl;
  import sap_clk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        auto_sw = 1'b0;
  logic        step_pb = 1'b0;
  logic        hlt = 1'b0;
  logic [2:0]  speed = 3'd0;
  logic [3:0]  blen = 4'd0;
  logic        clk_en;
  logic        mode_auto;
  logic        halted;
  logic [15:0] step_count;
  state_t      dbg_state;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;

  sap_clock_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_DIV_BASE   (4),
    .SPEED_W         (3),
    .BURST_W         (4),
    .CNT_W           (16)
  ) dut (
    .sap_base_clock    (clk),
    .sap_CleanStart_pb (rst_n),
    .sap_ManualAuto_sw (auto_sw),
    .sap_SingleStep_pb (step_pb),
    .sap_speed_sel     (speed),
    .sap_burst_len     (blen),
    .sap_hlt           (hlt),
    .sap_clk_en        (clk_en),
    .sap_mode_auto     (mode_auto),
    .sap_halted        (halted),
    .sap_step_count    (step_count),
    .o_dbg_state       (dbg_state)
  );

  // clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // driver and check helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input int cnt);
    logic [31:0] a;
    logic [15:0] n;
    a = at;
    n = cnt[15:0];
    exp_q.push_back({a, n});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input logic [2:0] spd, input logic [3:0] len);
    @(negedge clk);
    rst_n   = 1'b0;
    auto_sw = 1'b0;
    step_pb = 1'b0;
    hlt     = 1'b0;
    speed   = spd;
    blen    = len;
    repeat (2) @(negedge clk);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_mode_auto", mode_auto, 0);
    chk("rst_halted", halted, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_state", dbg_state, MANUAL);
    rst_n = 1'b1;
  endtask

  // scoreboard monitor: pops an expectation on every pulse, flags missed ones
  always @(negedge clk) begin
    if (clk_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_cycle", cyc, mon_e[47:16]);
        chk("pulse_count", step_count, {16'd0, mon_e[15:0]});
      end
    end else if (exp_q.size() > 0 && exp_q[0][47:16] < cyc) begin
      mon_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_pulse: got none expected pulse at cycle %0d", mon_e[47:16]);
    end
  end

  int c;
  int s;

  initial begin
    // 1 + 4: auto mode, speed 0 then 2 mid-period, drop to manual on a tick
    do_reset(3'd0, 4'd0);
    c = cyc + 10;
    wait_to(c);
    auto_sw = 1'b1;
    for (int k = 1; k <= 11; k++) expect_pulse(c + 7 + 4 * k, k);
    expect_pulse(c + 67, 12);
    expect_pulse(c + 83, 13);
    wait_to(c + 5);
    chk("mode_auto_before", mode_auto, 0);
    wait_to(c + 6);
    chk("mode_auto_rise", mode_auto, 1);
    wait_to(c + 47);
    chk("auto_count_40", step_count, 10);
    wait_to(c + 49);
    speed = 3'd2;
    wait_to(c + 92);
    auto_sw = 1'b0;
    wait_to(c + 105);
    chk("auto_exit_state", dbg_state, MANUAL);
    chk("auto_exit_count", step_count, 13);
    chk("auto_exit_mode", mode_auto, 0);

    // 2: burst of 3 at speed 1
    do_reset(3'd1, 4'd3);
    s = cyc + 20;
    wait_to(s);
    step_pb = 1'b1;
    expect_pulse(s + 15, 1);
    expect_pulse(s + 23, 2);
    expect_pulse(s + 31, 3);
    wait_to(s + 8);
    step_pb = 1'b0;
    wait_to(s + 40);
    chk("burst3_count", step_count, 3);
    chk("burst3_state", dbg_state, MANUAL);

    // 3: burst length 0 acts as 1, then a 3-cycle glitch does nothing
    s = cyc;
    blen = 4'd0;
    step_pb = 1'b1;
    expect_pulse(s + 15, 4);
    wait_to(s + 8);
    step_pb = 1'b0;
    wait_to(s + 40);
    chk("burst0_count", step_count, 4);
    s = cyc;
    step_pb = 1'b1;
    wait_to(s + 3);
    step_pb = 1'b0;
    wait_to(s + 30);
    chk("glitch_count", step_count, 4);
    chk("glitch_state", dbg_state, MANUAL);

    // 5: halt on a tick cycle, then inputs are ignored
    do_reset(3'd0, 4'd2);
    c = cyc + 10;
    wait_to(c);
    auto_sw = 1'b1;
    expect_pulse(c + 11, 1);
    wait_to(c + 14);
    hlt = 1'b1;
    wait_to(c + 15);
    chk("halt_flag", halted, 1);
    wait_to(c + 16);
    hlt = 1'b0;
    auto_sw = 1'b0;
    step_pb = 1'b1;
    wait_to(c + 24);
    step_pb = 1'b0;
    wait_to(c + 60);
    chk("halt_sticky", halted, 1);
    chk("halt_state", dbg_state, HALT);
    chk("halt_count", step_count, 1);

    // 6: reset during a burst pulse with two enables still to go
    do_reset(3'd1, 4'd3);
    s = cyc + 20;
    wait_to(s);
    step_pb = 1'b1;
    expect_pulse(s + 15, 1);
    wait_to(s + 8);
    step_pb = 1'b0;
    wait_to(s + 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_clk_en", clk_en, 0);
    chk("abort_count", step_count, 0);
    chk("abort_halted", halted, 0);
    chk("abort_mode", mode_auto, 0);
    chk("abort_state", dbg_state, MANUAL);
    @(negedge clk);
    rst_n = 1'b1;
    s = cyc;
    wait_to(s + 40);
    chk("post_abort_count", step_count, 0);
    chk("post_abort_state", dbg_state, MANUAL);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
